// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and the multicycle control unit:
// FSM state encoding, funct3 access-size/sign constants and a legality helper.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [2:0] funct3_t;

    localparam funct3_t F3_LB  = 3'b000;
    localparam funct3_t F3_LH  = 3'b001;
    localparam funct3_t F3_LW  = 3'b010;
    localparam funct3_t F3_LBU = 3'b100;
    localparam funct3_t F3_LHU = 3'b101;

    // funct3[1:0] encodes the access size; funct3[2] selects zero-extension
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic isLegalFunct3(input funct3_t f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle control unit and the memory responder.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    funct3_t     iFunct3;
    logic [31:0] oRData;
    logic        oReady;
    logic        oFault;

    modport master (
        output iMemRead, iMemWrite, iAddr, iWData, iFunct3,
        input  oRData, oReady, oFault
    );

    modport slave (
        input  iMemRead, iMemWrite, iAddr, iWData, iFunct3,
        output oRData, oReady, oFault
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM with per-byte write enables and registered read.
// Contents are deliberately not reset.
module mem_array #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              iClk,
    input  logic [3:0]        iWe,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [31:0]       iWData,
    output logic [31:0]       oRData
);
    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // byte-lane writes and registered read of the addressed word
    always_ff @(posedge iClk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (iWe[i]) begin
                mem[iAddr][8*i +: 8] <= iWData[8*i +: 8];
            end
        end
        oRData <= mem[iAddr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for a multicycle core: accepts one load/store at a time,
// waits LATENCY cycles, then completes with a one-cycle oReady pulse.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic           iClk,
    input  logic           iRstN,
    mem_responder_if.slave bus
);
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t            state, stateNext;
    logic [3:0]        cnt;
    logic [ADDR_W+1:0] addrQ;
    logic [31:0]       wdataQ;
    funct3_t           f3Q;
    logic              writeQ;
    logic [31:0]       rdataQ;

    logic              accept, fault, loadOk;
    logic [ADDR_W-1:0] ramAddr;
    logic [3:0]        ramWe, laneMask;
    logic [31:0]       ramWData, laneData, ramRData, laneWord, loadData;
    logic              unusedAddr;

    assign accept     = (state == IDLE) && (bus.iMemRead || bus.iMemWrite);
    assign unusedAddr = ^bus.iAddr[31:ADDR_W+2];

    // The RAM sees the live bus address while idle so that its registered read
    // is already valid in RESP even when LATENCY is 0.
    assign ramAddr = (state == IDLE) ? bus.iAddr[ADDR_W+1:2] : addrQ[ADDR_W+1:2];

    // state register
    always_ff @(posedge iClk) begin
        if (!iRstN) state <= IDLE;
        else        state <= stateNext;
    end

    // next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = (LAT == 4'd0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // wait counter: loaded on acceptance, counts down while waiting
    always_ff @(posedge iClk) begin
        if (!iRstN)             cnt <= '0;
        else if (accept)        cnt <= LAT;
        else if (state == WAIT) cnt <= cnt - 4'd1;
    end

    // request capture; a simultaneous read and write is taken as a write
    always_ff @(posedge iClk) begin
        if (accept) begin
            addrQ  <= bus.iAddr[ADDR_W+1:0];
            wdataQ <= bus.iWData;
            f3Q    <= bus.iFunct3;
            writeQ <= bus.iMemWrite;
        end
    end

    // fault detection: illegal funct3 or misaligned half/word
    always_comb begin
        fault = !isLegalFunct3(f3Q);
        case (f3Q[1:0])
            SZ_HALF: if (addrQ[0]) fault = 1'b1;
            SZ_WORD: if (addrQ[1:0] != 2'b00) fault = 1'b1;
            default: ;
        endcase
    end

    // store lane selection; write fires on the edge leaving RESP unless reset
    always_comb begin
        laneMask = '0;
        laneData = wdataQ;
        case (f3Q[1:0])
            SZ_BYTE: begin
                laneMask = 4'b0001 << addrQ[1:0];
                laneData = {4{wdataQ[7:0]}};
            end
            SZ_HALF: begin
                laneMask = addrQ[1] ? 4'b1100 : 4'b0011;
                laneData = {2{wdataQ[15:0]}};
            end
            SZ_WORD: laneMask = '1;
            default: laneMask = '0;
        endcase
        ramWe    = (state == RESP && writeQ && !fault && iRstN) ? laneMask : '0;
        ramWData = laneData;
    end

    // load alignment and sign/zero extension
    always_comb begin
        laneWord = ramRData >> {addrQ[1:0], 3'b000};
        case (f3Q)
            F3_LB:   loadData = {{24{laneWord[7]}}, laneWord[7:0]};
            F3_LBU:  loadData = {24'h0, laneWord[7:0]};
            F3_LH:   loadData = {{16{laneWord[15]}}, laneWord[15:0]};
            F3_LHU:  loadData = {16'h0, laneWord[15:0]};
            default: loadData = laneWord;
        endcase
    end

    assign loadOk = (state == RESP) && !writeQ && !fault;

    // last successful load is held between completions
    always_ff @(posedge iClk) begin
        if (!iRstN)      rdataQ <= '0;
        else if (loadOk) rdataQ <= loadData;
    end

    assign bus.oRData = loadOk ? loadData : rdataQ;
    assign bus.oReady = (state == RESP);
    assign bus.oFault = (state == RESP) && fault;

    mem_array #(
        .ADDR_W (ADDR_W)
    ) uMem (
        .iClk   (iClk),
        .iWe    (ramWe),
        .iAddr  (ramAddr),
        .iWData (ramWData),
        .oRData (ramRData)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboard of expected completions,
// plus a LATENCY=0 instance for back-to-back request behaviour.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int unsigned LAT = 2;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic iClk;
    logic iRstN;
    int   checks;
    int   errors;
    exp_t sbq[$];
    logic [31:0] lastRd;

    mem_responder_if bus ();
    mem_responder_if bus0 ();

    mem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .bus   (bus)
    );

    mem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
        .iClk  (iClk),
        .iRstN (iRstN),
        .bus   (bus0)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // one request on the LATENCY=2 instance; expectation pushed at drive time,
    // popped when oReady is observed
    task automatic access(input string tag, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input logic [31:0] expData,
                          input bit expFault);
        exp_t e;
        int   n;
        bit   seen;
        e.tag = tag; e.data = expData; e.fault = expFault;
        sbq.push_back(e);
        bus.iMemRead = rd; bus.iMemWrite = wr;
        bus.iAddr = addr; bus.iWData = wd; bus.iFunct3 = f3;
        @(posedge iClk); #1;
        bus.iMemRead = 1'b0; bus.iMemWrite = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge iClk);
            n++;
            if (bus.oReady) seen = 1'b1;
            else checkVal({tag, "_faultIdle"}, 32'(bus.oFault), 32'd0);
        end
        e = sbq.pop_front();
        if (!seen) begin
            checkVal({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            checkVal({tag, "_lat"}, 32'(n), 32'(LAT + 1));
            checkVal({e.tag, "_data"}, bus.oRData, e.data);
            checkVal({e.tag, "_fault"}, 32'(bus.oFault), 32'(e.fault));
        end
        @(negedge iClk);
        checkVal({tag, "_pulse"}, 32'(bus.oReady), 32'd0);
    endtask

    task automatic wrAcc(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, input bit expFault);
        access(tag, 1'b0, 1'b1, addr, wd, f3, lastRd, expFault);
    endtask

    task automatic rdAcc(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] expData, input bit expFault);
        access(tag, 1'b1, 1'b0, addr, 32'h0, f3, expFault ? lastRd : expData, expFault);
        if (!expFault) lastRd = expData;
    endtask

    initial begin
        int   pulses;
        logic prev;
        checks = 0; errors = 0; lastRd = 32'h0;
        iRstN = 1'b0;
        bus.iMemRead = 1'b0; bus.iMemWrite = 1'b0; bus.iAddr = '0; bus.iWData = '0; bus.iFunct3 = '0;
        bus0.iMemRead = 1'b0; bus0.iMemWrite = 1'b0; bus0.iAddr = '0; bus0.iWData = '0; bus0.iFunct3 = '0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        checkVal("rstReady", 32'(bus.oReady), 32'd0);
        checkVal("rstFault", 32'(bus.oFault), 32'd0);
        checkVal("rstRData", bus.oRData, 32'h0);
        @(posedge iClk); #1;
        iRstN = 1'b1;

        wrAcc("sw0",   32'h0, 32'h12345678, F3_LW, 1'b0);
        rdAcc("lw0",   32'h0, F3_LW, 32'h12345678, 1'b0);
        wrAcc("sw4",   32'h4, 32'h11223344, F3_LW, 1'b0);
        wrAcc("sb6",   32'h6, 32'h000000AB, F3_LB, 1'b0);
        rdAcc("lb6",   32'h6, F3_LB,  32'hFFFFFFAB, 1'b0);
        rdAcc("lbu6",  32'h6, F3_LBU, 32'h000000AB, 1'b0);
        rdAcc("lw4a",  32'h4, F3_LW,  32'h11AB3344, 1'b0);
        rdAcc("lh6",   32'h6, F3_LH,  32'h000011AB, 1'b0);
        wrAcc("sh4",   32'h4, 32'h0000BEEF, F3_LH, 1'b0);
        rdAcc("lh4",   32'h4, F3_LH,  32'hFFFFBEEF, 1'b0);
        rdAcc("lhu4",  32'h4, F3_LHU, 32'h0000BEEF, 1'b0);
        rdAcc("lw4b",  32'h4, F3_LW,  32'h11ABBEEF, 1'b0);

        wrAcc("swMis", 32'h2, 32'hFFFFFFFF, F3_LW, 1'b1);
        rdAcc("lw0b",  32'h0, F3_LW, 32'h12345678, 1'b0);
        rdAcc("lhMis", 32'h5, F3_LH, 32'h0, 1'b1);
        rdAcc("lwIll", 32'h4, 3'b011, 32'h0, 1'b1);
        wrAcc("sIll",  32'h4, 32'h00000000, 3'b110, 1'b1);
        rdAcc("lw4c",  32'h4, F3_LW,  32'h11ABBEEF, 1'b0);
        rdAcc("lbu7",  32'h7, F3_LBU, 32'h00000011, 1'b0);
        rdAcc("lb4",   32'h4, F3_LB,  32'hFFFFFFEF, 1'b0);

        access("rdwr8", 1'b1, 1'b1, 32'h8, 32'h55AA55AA, F3_LW, lastRd, 1'b0);
        rdAcc("lw8",   32'h8, F3_LW, 32'h55AA55AA, 1'b0);

        // store aborted by reset while waiting
        wrAcc("sw10",  32'h10, 32'h0BADF00D, F3_LW, 1'b0);
        bus.iMemWrite = 1'b1; bus.iAddr = 32'h10; bus.iWData = 32'hDEADBEEF; bus.iFunct3 = F3_LW;
        @(posedge iClk); #1;
        bus.iMemWrite = 1'b0;
        @(negedge iClk);
        iRstN = 1'b0;
        repeat (2) begin
            @(negedge iClk);
            checkVal("abortNoReady", 32'(bus.oReady), 32'd0);
        end
        @(posedge iClk); #1;
        iRstN = 1'b1;
        repeat (3) begin
            @(negedge iClk);
            checkVal("abortNoReadyPost", 32'(bus.oReady), 32'd0);
        end
        checkVal("abortRData", bus.oRData, 32'h0);
        lastRd = 32'h0;
        rdAcc("lw10",  32'h10, F3_LW, 32'h0BADF00D, 1'b0);

        // upper address bits wrap
        wrAcc("sw0c",  32'h0, 32'hCAFEF00D, F3_LW, 1'b0);
        rdAcc("lwWrap", 32'h1000, F3_LW, 32'hCAFEF00D, 1'b0);

        // LATENCY=0 instance: one store, then a read held high for 10 cycles
        bus0.iMemWrite = 1'b1; bus0.iAddr = 32'h0; bus0.iWData = 32'hA5A5A5A5; bus0.iFunct3 = F3_LW;
        @(posedge iClk); #1;
        bus0.iMemWrite = 1'b0;
        @(negedge iClk);
        checkVal("z_swReady", 32'(bus0.oReady), 32'd1);
        @(posedge iClk); #1;
        bus0.iMemRead = 1'b1;
        pulses = 0; prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge iClk);
            if (bus0.oReady) begin
                pulses++;
                checkVal("z_burstData", bus0.oRData, 32'hA5A5A5A5);
                checkVal("z_burstFault", 32'(bus0.oFault), 32'd0);
            end
            checkVal("z_noDouble", 32'(bus0.oReady && prev), 32'd0);
            prev = bus0.oReady;
        end
        bus0.iMemRead = 1'b0;
        checkVal("z_pulseCount", 32'(pulses), 32'd5);

        checkVal("sbEmpty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
